vga_char_render: RTL

- Character renderer sitting directly upstream of the VGA framebuffer driver.
- Accepts one character command per handshake (code, cell column/row, fg/bg colour).
- Fetches glyph rows from an external synchronous 8x16 font ROM.
- Emits one framebuffer pixel write per cycle on a write_addr/write_data/write_enable port that connects straight to the VGA driver's write port.
- The framebuffer is 400x300 at 8 bpp (RRRGGGBB), with a line stride of 2^STRIDE_SHIFT pixels.

---
 rtl/vga_char_render.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_char_render.sv
// vga_char_render: draws one 8x16 character cell into a 400x300 8bpp framebuffer.
// A command (code, cell column/row, fg/bg colour) is accepted in IDLE. For each
// of the 16 glyph rows the font ROM is read (FETCH), its output latched (LATCH)
// and eight pixel writes are issued (DRAW), one per clock, on a write port that
// feeds the VGA driver directly. Commands addressing cells outside the visible
// grid are accepted and dropped silently.
// Optional build macro VGA_CHAR_RENDER_TRANSPARENT_EN: glyph 0-bits are skipped
// (write_enable stays low) so background pixels keep prior framebuffer contents.
module vga_char_render #(
    parameter int ADDR_WIDTH   = 18,
    parameter int STRIDE_SHIFT = 9,
    parameter int COLS         = 50,
    parameter int ROWS         = 18
) (
    input  logic                  clk50M,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_char,
    input  logic [5:0]            in_col,
    input  logic [4:0]            in_row,
    input  logic [7:0]            in_fg,
    input  logic [7:0]            in_bg,
    output logic [10:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [7:0]            write_data,
    output logic                  write_enable,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_DRAW  = 2'd3
    } state_t;

    state_t          state_r;
    logic [6:0]      char_r;
    logic [5:0]      col_r;
    logic [4:0]      row_r;
    logic [7:0]      fg_r;
    logic [7:0]      bg_r;
    logic [3:0]      glyph_row_r;
    logic [2:0]      px_r;
    // Remaining glyph bits after the leftmost one; bit 6 is the next pixel.
    logic [6:0]      glyph_r;

    logic                  pix_bit_s;
    logic [2:0]            next_px_s;
    logic [8:0]            line_s;
    logic [ADDR_WIDTH-1:0] pix_addr_s;
    logic [7:0]            pix_color_s;
    logic                  emit_we_s;
    logic                  cmd_ok_s;

    // Next pixel to present: outputs are registered, so the pixel shown in a
    // DRAW cycle is computed one cycle earlier (pixel 0 straight from the ROM).
    always_comb begin
        pix_bit_s   = 1'b0;
        next_px_s   = 3'd0;
        line_s      = {row_r, glyph_row_r};
        pix_addr_s  = '0;
        pix_color_s = 8'd0;
        emit_we_s   = 1'b0;
        cmd_ok_s    = 1'b0;

        if (state_r == ST_LATCH) begin
            pix_bit_s = font_data[7];
            next_px_s = 3'd0;
        end else begin
            pix_bit_s = glyph_r[6];
            next_px_s = px_r + 3'd1;
        end

        // line = row*16 + r; address arithmetic wraps at ADDR_WIDTH.
        pix_addr_s  = (ADDR_WIDTH'(line_s) << STRIDE_SHIFT)
                    + (ADDR_WIDTH'(col_r) << 3)
                    + ADDR_WIDTH'(next_px_s);
        pix_color_s = pix_bit_s ? fg_r : bg_r;

`ifdef VGA_CHAR_RENDER_TRANSPARENT_EN
        emit_we_s = pix_bit_s;
`else
        emit_we_s = 1'b1;
`endif

        cmd_ok_s = (int'(in_col) < COLS) && (int'(in_row) < ROWS);
    end

    // Command sequencer and registered framebuffer/font-ROM outputs.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            char_r       <= 7'd0;
            col_r        <= 6'd0;
            row_r        <= 5'd0;
            fg_r         <= 8'd0;
            bg_r         <= 8'd0;
            glyph_row_r  <= 4'd0;
            px_r         <= 3'd0;
            glyph_r      <= 7'd0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            font_addr    <= 11'd0;
            write_addr   <= '0;
            write_data   <= 8'd0;
            write_enable <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    write_enable <= 1'b0;
                    if (in_valid) begin
                        char_r      <= in_char;
                        col_r       <= in_col;
                        row_r       <= in_row;
                        fg_r        <= in_fg;
                        bg_r        <= in_bg;
                        glyph_row_r <= 4'd0;
                        if (cmd_ok_s) begin
                            // font_addr is registered so it is valid during FETCH.
                            font_addr <= {in_char, 4'd0};
                            state_r   <= ST_FETCH;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            // Off-screen cell: swallow the command, stay ready.
                            state_r  <= ST_IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        state_r  <= ST_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    // ROM samples font_addr at the end of this cycle.
                    write_enable <= 1'b0;
                    state_r      <= ST_LATCH;
                end

                ST_LATCH: begin
                    glyph_r      <= font_data[6:0];
                    px_r         <= 3'd0;
                    state_r      <= ST_DRAW;
                    write_enable <= emit_we_s;
                    if (emit_we_s) begin
                        write_addr <= pix_addr_s;
                        write_data <= pix_color_s;
                    end else begin
                        write_addr <= write_addr;
                        write_data <= write_data;
                    end
                end

                ST_DRAW: begin
                    if (px_r != 3'd7) begin
                        px_r         <= next_px_s;
                        glyph_r      <= {glyph_r[5:0], 1'b0};
                        write_enable <= emit_we_s;
                        if (emit_we_s) begin
                            write_addr <= pix_addr_s;
                            write_data <= pix_color_s;
                        end else begin
                            write_addr <= write_addr;
                            write_data <= write_data;
                        end
                    end else begin
                        write_enable <= 1'b0;
                        if (glyph_row_r != 4'd15) begin
                            glyph_row_r <= glyph_row_r + 4'd1;
                            font_addr   <= {char_r, glyph_row_r + 4'd1};
                            state_r     <= ST_FETCH;
                        end else begin
                            state_r  <= ST_IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_r      <= ST_IDLE;
                    in_ready     <= 1'b1;
                    busy         <= 1'b0;
                    write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
